// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipeline computing one of eight bitwise ops with zero/parity flags.
// Defining LOGIC_UNIT_COUNT_EN adds the saturating completed-result counter op_count.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity
`ifdef LOGIC_UNIT_COUNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NOT_A  = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("logic_unit_pipe: WIDTH and CNT_W must be at least 1");
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_y;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_zero;
    logic             s2_parity;

    logic             s1_adv;
    logic             s2_adv;

    // A stage may load whenever it is empty or its content is leaving this cycle.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= op_e'(in_op);
            end
        end
    end

    always_comb begin
        s1_y = '0;
        case (s1_op)
            OP_AND:    s1_y = s1_a & s1_b;
            OP_OR:     s1_y = s1_a | s1_b;
            OP_NOT_A:  s1_y = ~s1_a;
            OP_NAND:   s1_y = ~(s1_a & s1_b);
            OP_NOR:    s1_y = ~(s1_a | s1_b);
            OP_XOR:    s1_y = s1_a ^ s1_b;
            OP_XNOR:   s1_y = ~(s1_a ^ s1_b);
            OP_PASS_B: s1_y = s1_b;
            default:   s1_y = '0;
        endcase
    end

    // Flags are registered with the result so out_* come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_y      <= '0;
            s2_zero   <= 1'b0;
            s2_parity <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y      <= s1_y;
                s2_zero   <= (s1_y == '0);
                s2_parity <= ^s1_y;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_y      = s2_y;
    assign out_zero   = s2_zero;
    assign out_parity = s2_parity;

`ifdef LOGIC_UNIT_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Saturates at all-ones so a long run never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (out_valid && out_ready && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign op_count = count_q;
`endif

endmodule
